// File: rtl/pkt_stream_checker.sv
// Packet sink/checker for the 64-bit data + 8-bit ctrl stream.
// Applies programmable backpressure and checks HDR/DATA/EOP framing.
// Keeps packet, word, byte and error counts plus a per-packet XOR signature.
module pkt_stream_checker #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CTRL_WIDTH = 8,
   parameter logic [CTRL_WIDTH-1:0] HDR_CTRL = 8'hFF,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
   input  logic                  in_wr_i,
   output logic                  in_rdy_o,
   input  logic [1:0]            stall_mode_i,
   input  logic                  clr_i,
   output logic [31:0]           pkt_cnt_o,
   output logic [31:0]           word_cnt_o,
   output logic [31:0]           byte_cnt_o,
   output logic [15:0]           err_cnt_o,
   output logic [DATA_WIDTH-1:0] last_sig_o,
   output logic                  pkt_done_o,
   output logic                  err_flag_o
);

   typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] sig_q, sig_d;
   logic [31:0]           pay_bytes_q, pay_bytes_d;
   logic [31:0]           pkt_cnt_q, pkt_cnt_d;
   logic [31:0]           word_cnt_q, word_cnt_d;
   logic [31:0]           byte_cnt_q, byte_cnt_d;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic [DATA_WIDTH-1:0] last_sig_q, last_sig_d;
   logic                  pkt_done_q, pkt_done_d;
   logic                  err_flag_q, err_flag_d;
   logic                  toggle_q, toggle_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic                  rdy_q, rdy_d;

   logic                  accept;
   logic                  is_hdr, is_data, is_eop;
   logic [31:0]           eop_bytes;
   logic                  complete, err;

   // Word classification and valid-byte count of an EOP word (MSB-first bytes)
   always_comb begin
      accept    = in_wr_i & rdy_q;
      is_hdr    = (in_ctrl_i == HDR_CTRL);
      is_data   = (in_ctrl_i == '0);
      is_eop    = !is_hdr && (in_ctrl_i != '0) &&
                  ((in_ctrl_i & (in_ctrl_i - 1'b1)) == '0);
      eop_bytes = '0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         if (in_ctrl_i[i]) eop_bytes = 32'(CTRL_WIDTH - i);
      end
   end

   // Framing FSM next state and signature / payload-byte accumulation
   always_comb begin
      state_d     = state_q;
      sig_d       = sig_q;
      pay_bytes_d = pay_bytes_q;
      complete    = 1'b0;
      err         = 1'b0;
      if (accept) begin
         case (state_q)
            StIdle: begin
               if (is_hdr) begin
                  state_d     = StHdr;
                  sig_d       = '0;
                  pay_bytes_d = '0;
               end else begin
                  err = 1'b1;
               end
            end
            StHdr, StPay: begin
               if (is_data) begin
                  state_d     = StPay;
                  sig_d       = sig_q ^ in_data_i;
                  pay_bytes_d = pay_bytes_q + 32'd8;
               end else if (is_eop) begin
                  state_d  = StIdle;
                  complete = 1'b1;
               end else if (is_hdr) begin
                  // Header inside a payload truncates that packet and starts a new one
                  if (state_q == StPay) begin
                     err         = 1'b1;
                     sig_d       = '0;
                     pay_bytes_d = '0;
                  end
                  state_d = StHdr;
               end else begin
                  err     = 1'b1;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Counters, signature capture, error flag and backpressure generation
   always_comb begin
      word_cnt_d = word_cnt_q + 32'(accept);
      pkt_cnt_d  = pkt_cnt_q;
      byte_cnt_d = byte_cnt_q;
      last_sig_d = last_sig_q;
      pkt_done_d = complete;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q | err;
      if (complete) begin
         pkt_cnt_d  = pkt_cnt_q + 32'd1;
         byte_cnt_d = byte_cnt_q + pay_bytes_q + eop_bytes;
         last_sig_d = sig_q ^ in_data_i;
      end
      if (err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      // Clear has priority over a completion or error in the same cycle
      if (clr_i) begin
         word_cnt_d = '0;
         pkt_cnt_d  = '0;
         byte_cnt_d = '0;
         last_sig_d = '0;
         pkt_done_d = 1'b0;
         err_cnt_d  = '0;
         err_flag_d = 1'b0;
      end

      toggle_d = ~toggle_q;
      lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      unique case (stall_mode_i)
         2'd0:    rdy_d = 1'b1;
         2'd1:    rdy_d = toggle_d;
         2'd2:    rdy_d = lfsr_d[0];
         default: rdy_d = 1'b0;
      endcase
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         sig_q       <= '0;
         pay_bytes_q <= '0;
         pkt_cnt_q   <= '0;
         word_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         err_cnt_q   <= '0;
         last_sig_q  <= '0;
         pkt_done_q  <= 1'b0;
         err_flag_q  <= 1'b0;
         toggle_q    <= 1'b0;
         lfsr_q      <= LFSR_SEED;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sig_q       <= sig_d;
         pay_bytes_q <= pay_bytes_d;
         pkt_cnt_q   <= pkt_cnt_d;
         word_cnt_q  <= word_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         err_cnt_q   <= err_cnt_d;
         last_sig_q  <= last_sig_d;
         pkt_done_q  <= pkt_done_d;
         err_flag_q  <= err_flag_d;
         toggle_q    <= toggle_d;
         lfsr_q      <= lfsr_d;
         rdy_q       <= rdy_d;
      end
   end

   assign in_rdy_o   = rdy_q;
   assign pkt_cnt_o  = pkt_cnt_q;
   assign word_cnt_o = word_cnt_q;
   assign byte_cnt_o = byte_cnt_q;
   assign err_cnt_o  = err_cnt_q;
   assign last_sig_o = last_sig_q;
   assign pkt_done_o = pkt_done_q;
   assign err_flag_o = err_flag_q;

endmodule

// File: tb/tb_pkt_stream_checker.sv
// Directed bench for pkt_stream_checker: inputs driven and outputs sampled on negedge.
module tb_pkt_stream_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic [1:0]  stall_mode;
   logic        clr;
   logic [31:0] pkt_cnt, word_cnt, byte_cnt;
   logic [15:0] err_cnt;
   logic [63:0] last_sig;
   logic        pkt_done, err_flag;

   int tests_run = 0;
   int failed = 0;

   logic [15:0] lfsr_m;

   always #5 clk = ~clk;

   pkt_stream_checker dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_data_i   (in_data),
      .in_ctrl_i   (in_ctrl),
      .in_wr_i     (in_wr),
      .in_rdy_o    (in_rdy),
      .stall_mode_i(stall_mode),
      .clr_i       (clr),
      .pkt_cnt_o   (pkt_cnt),
      .word_cnt_o  (word_cnt),
      .byte_cnt_o  (byte_cnt),
      .err_cnt_o   (err_cnt),
      .last_sig_o  (last_sig),
      .pkt_done_o  (pkt_done),
      .err_flag_o  (err_flag)
   );

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 16'hACE1;
      else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   // Present one word at a negedge and hold it until accepted (bounded)
   task automatic send(input logic [63:0] d, input logic [7:0] c);
      logic acc;
      int   n;
      in_data = d;
      in_ctrl = c;
      in_wr   = 1'b1;
      acc     = 1'b0;
      n       = 0;
      while (!acc && n < 300) begin
         acc = in_rdy;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      in_wr = 1'b0;
      if (!acc) begin
         tests_run++; failed++;
         $display("FAIL send_timeout: word ctrl=%h not accepted in %0d cycles", c, n);
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({pkt_cnt, word_cnt, byte_cnt, err_cnt, last_sig, pkt_done, err_flag, in_rdy} !== '0) begin
         failed++; $display("FAIL reset_outputs: got pkt=%h word=%h byte=%h err=%h sig=%h done=%b flag=%b rdy=%b, want all 0",
                            pkt_cnt, word_cnt, byte_cnt, err_cnt, last_sig, pkt_done, err_flag, in_rdy);
      end
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (in_rdy !== 1'b0) begin failed++; $display("FAIL mode1_first_cycle: rdy=%b want 0", in_rdy); end
      @(negedge clk);
      tests_run++;
      if (in_rdy !== 1'b1) begin failed++; $display("FAIL mode1_second_cycle: rdy=%b want 1", in_rdy); end
      @(negedge clk);
      tests_run++;
      if (in_rdy !== 1'b0) begin failed++; $display("FAIL mode1_third_cycle: rdy=%b want 0", in_rdy); end
   endtask

   task automatic test_basic();
      stall_mode = 2'd0;
      @(negedge clk);
      send(64'hDEAD, 8'hFF);
      send(64'h1, 8'h00);
      send(64'h2, 8'h00);
      send(64'h4, 8'h10);
      tests_run++;
      if (pkt_done !== 1'b1) begin failed++; $display("FAIL basic_done: got %b want 1", pkt_done); end
      tests_run++;
      if (pkt_cnt !== 32'd1) begin failed++; $display("FAIL basic_pkt: got %0d want 1", pkt_cnt); end
      tests_run++;
      if (word_cnt !== 32'd4) begin failed++; $display("FAIL basic_word: got %0d want 4", word_cnt); end
      tests_run++;
      if (byte_cnt !== 32'd20) begin failed++; $display("FAIL basic_byte: got %0d want 20", byte_cnt); end
      tests_run++;
      if (last_sig !== 64'h7) begin failed++; $display("FAIL basic_sig: got %h want 7", last_sig); end
      tests_run++;
      if (err_cnt !== 16'd0) begin failed++; $display("FAIL basic_err: got %0d want 0", err_cnt); end
      @(negedge clk);
      tests_run++;
      if (pkt_done !== 1'b0) begin failed++; $display("FAIL basic_done_pulse: got %b want 0", pkt_done); end
   endtask

   task automatic test_sig_overwrite();
      send(64'h0, 8'hFF);
      send(64'hF0, 8'h80);
      tests_run++;
      if (last_sig !== 64'hF0) begin failed++; $display("FAIL sig_overwrite: got %h want f0", last_sig); end
      tests_run++;
      if (byte_cnt !== 32'd21) begin failed++; $display("FAIL sig_byte: got %0d want 21", byte_cnt); end
      tests_run++;
      if (pkt_cnt !== 32'd2 || word_cnt !== 32'd6) begin
         failed++; $display("FAIL sig_counts: pkt=%0d word=%0d want 2/6", pkt_cnt, word_cnt);
      end
   endtask

   task automatic test_errors();
      pulse_clr();
      tests_run++;
      if ({pkt_cnt, word_cnt, byte_cnt, err_cnt, last_sig, err_flag} !== '0) begin
         failed++; $display("FAIL clr_all: pkt=%0d word=%0d byte=%0d err=%0d sig=%h flag=%b want all 0",
                            pkt_cnt, word_cnt, byte_cnt, err_cnt, last_sig, err_flag);
      end
      send(64'h11, 8'h00);
      tests_run++;
      if (err_cnt !== 16'd1 || err_flag !== 1'b1) begin
         failed++; $display("FAIL err_idle: err=%0d flag=%b want 1/1", err_cnt, err_flag);
      end
      send(64'h0, 8'hFF);
      send(64'h22, 8'h00);
      send(64'h33, 8'h03);
      tests_run++;
      if (err_cnt !== 16'd2 || err_flag !== 1'b1) begin
         failed++; $display("FAIL err_bad: err=%0d flag=%b want 2/1", err_cnt, err_flag);
      end
      tests_run++;
      if (pkt_cnt !== 32'd0 || byte_cnt !== 32'd0 || word_cnt !== 32'd4) begin
         failed++; $display("FAIL err_counts: pkt=%0d byte=%0d word=%0d want 0/0/4", pkt_cnt, byte_cnt, word_cnt);
      end
   endtask

   task automatic test_truncated();
      pulse_clr();
      send(64'h0, 8'hFF);
      send(64'h55, 8'h00);
      send(64'h0, 8'hFF);
      send(64'h99, 8'h01);
      tests_run++;
      if (err_cnt !== 16'd1 || pkt_cnt !== 32'd1 || byte_cnt !== 32'd8) begin
         failed++; $display("FAIL truncated: err=%0d pkt=%0d byte=%0d want 1/1/8", err_cnt, pkt_cnt, byte_cnt);
      end
      tests_run++;
      if (last_sig !== 64'h99) begin failed++; $display("FAIL truncated_sig: got %h want 99", last_sig); end
   endtask

   task automatic test_clr_vs_complete();
      pulse_clr();
      send(64'h0, 8'hFF);
      send(64'h9, 8'h00);
      clr = 1'b1;
      send(64'h7, 8'h01);
      clr = 1'b0;
      tests_run++;
      if ({pkt_cnt, word_cnt, byte_cnt, last_sig, pkt_done} !== '0) begin
         failed++; $display("FAIL clr_wins: pkt=%0d word=%0d byte=%0d sig=%h done=%b want all 0",
                            pkt_cnt, word_cnt, byte_cnt, last_sig, pkt_done);
      end
      send(64'h0, 8'hFF);
      send(64'hAB, 8'h02);
      tests_run++;
      if (pkt_cnt !== 32'd1 || byte_cnt !== 32'd7 || last_sig !== 64'hAB || word_cnt !== 32'd2) begin
         failed++; $display("FAIL after_clr_pkt: pkt=%0d byte=%0d sig=%h word=%0d want 1/7/ab/2",
                            pkt_cnt, byte_cnt, last_sig, word_cnt);
      end
   endtask

   task automatic test_mode3();
      stall_mode = 2'd3;
      pulse_clr();
      in_data = 64'h0;
      in_ctrl = 8'hFF;
      in_wr   = 1'b1;
      repeat (5) @(negedge clk);
      tests_run++;
      if (in_rdy !== 1'b0 || word_cnt !== 32'd0) begin
         failed++; $display("FAIL mode3_frozen: rdy=%b word=%0d want 0/0", in_rdy, word_cnt);
      end
      in_wr = 1'b0;
   endtask

   task automatic test_mode2();
      int bad;
      stall_mode = 2'd2;
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (in_rdy !== lfsr_m[0]) bad++;
         @(negedge clk);
      end
      tests_run++;
      if (bad != 0) begin failed++; $display("FAIL mode2_lfsr: %0d cycles rdy differed from lfsr bit0, want 0", bad); end
      pulse_clr();
      for (int i = 0; i < 5; i++) begin
         send(64'h0, 8'hFF);
         send(64'(i), 8'h00);
         send(64'(i + 100), 8'h01);
      end
      tests_run++;
      if (pkt_cnt !== 32'd5 || word_cnt !== 32'd15 || byte_cnt !== 32'd80 || err_cnt !== 16'd0) begin
         failed++; $display("FAIL mode2_stream: pkt=%0d word=%0d byte=%0d err=%0d want 5/15/80/0",
                            pkt_cnt, word_cnt, byte_cnt, err_cnt);
      end
      tests_run++;
      if (last_sig !== (64'd4 ^ 64'd104)) begin
         failed++; $display("FAIL mode2_sig: got %h want %h", last_sig, 64'd4 ^ 64'd104);
      end
      stall_mode = 2'd0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      send(64'h0, 8'hFF);
      send(64'h3, 8'h00);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({pkt_cnt, word_cnt, byte_cnt, err_cnt, last_sig, pkt_done, err_flag, in_rdy} !== '0) begin
         failed++; $display("FAIL midreset_outputs: pkt=%0d word=%0d byte=%0d err=%0d sig=%h rdy=%b want all 0",
                            pkt_cnt, word_cnt, byte_cnt, err_cnt, last_sig, in_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(64'h0, 8'hFF);
      send(64'h5, 8'h00);
      send(64'h6, 8'h01);
      tests_run++;
      if (pkt_cnt !== 32'd1 || err_cnt !== 16'd0 || byte_cnt !== 32'd16 || word_cnt !== 32'd3) begin
         failed++; $display("FAIL midreset_pkt: pkt=%0d err=%0d byte=%0d word=%0d want 1/0/16/3",
                            pkt_cnt, err_cnt, byte_cnt, word_cnt);
      end
      tests_run++;
      if (last_sig !== 64'h3) begin failed++; $display("FAIL midreset_sig: got %h want 3", last_sig); end
   endtask

   initial begin
      rst_n      = 1'b0;
      in_data    = '0;
      in_ctrl    = '0;
      in_wr      = 1'b0;
      stall_mode = 2'd1;
      clr        = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_sig_overwrite();
      test_errors();
      test_truncated();
      test_clr_vs_complete();
      test_mode3();
      test_mode2();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
